// File: rtl/acc_lut_arb.sv
// Round-robin arbiter sharing one combinational accumulator-constant LUT between two ports.
// Optional per-port saturating grant counters are enabled with ACC_LUT_ARB_CNT_EN.
module acc_lut_arb #(
  parameter int unsigned KEY_W = 5,
  parameter int unsigned VAL_W = 8
`ifdef ACC_LUT_ARB_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  input  logic [2*KEY_W-1:0]   req_key,
  output logic [1:0]           req_ready,
  output logic [1:0]           resp_valid,
  output logic [2*VAL_W-1:0]   resp_value,
  input  logic [1:0]           resp_ready,
  output logic                 lut_en,
  output logic [KEY_W-1:0]     lut_key,
  input  logic [VAL_W-1:0]     lut_value
`ifdef ACC_LUT_ARB_CNT_EN
  ,
  output logic [2*CNT_W-1:0]   grant_cnt
`endif
);

  logic [1:0]         r_resp_valid;
  logic [2*VAL_W-1:0] r_resp_value;
  logic               r_last;
  logic [1:0]         w_elig;
  logic [1:0]         w_gnt;

  // A port may issue only if its response slot is free or drains this cycle; nothing is granted in reset.
  always_comb begin
    w_elig = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_elig[i] = rst_n && req_valid[i] && (!r_resp_valid[i] || resp_ready[i]);
    end
    w_gnt    = 2'b00;
    w_gnt[0] = w_elig[0] && (!w_elig[1] || r_last);
    w_gnt[1] = w_elig[1] && (!w_elig[0] || !r_last);
  end

  always_comb begin
    lut_en  = w_gnt[0] || w_gnt[1];
    lut_key = '0;
    if (w_gnt[0]) begin
      lut_key = req_key[0 +: KEY_W];
    end else if (w_gnt[1]) begin
      lut_key = req_key[KEY_W +: KEY_W];
    end
  end

  assign req_ready  = w_gnt;
  assign resp_valid = r_resp_valid;
  assign resp_value = r_resp_value;

  // Response slots: a new grant overwrites, a drain without a grant clears only the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 2'b00;
      r_resp_value <= '0;
      r_last       <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_gnt[i]) begin
          r_resp_valid[i]               <= 1'b1;
          r_resp_value[i*VAL_W +: VAL_W] <= lut_value;
        end else if (resp_ready[i]) begin
          r_resp_valid[i] <= 1'b0;
        end
      end
      if (w_gnt[0] || w_gnt[1]) begin
        r_last <= w_gnt[1];
      end
    end
  end

`ifdef ACC_LUT_ARB_CNT_EN
  logic [2*CNT_W-1:0] r_cnt;

  // Saturating grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_gnt[i] && (r_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          r_cnt[i*CNT_W +: CNT_W] <= r_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign grant_cnt = r_cnt;
`endif

endmodule
